// File: rtl/regbank_dump_tx_if.sv
// Output stream of the register-dump transmitter: one {index, value} word per transfer.
interface regbank_dump_tx_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    // A word moves on a clock edge where out_valid && out_ready are both high. The
    // master keeps out_valid, out_index and out_data stable until that edge, and
    // never waits for out_ready before raising out_valid.
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_index;
    logic [DATA_W-1:0] out_data;

    modport master (output out_valid, output out_index, output out_data, input out_ready);
    modport slave  (input out_valid, input out_index, input out_data, output out_ready);
endinterface

// File: rtl/regbank_dump_tx.sv
// Walks a (possibly wrapping) range of register indices, reads each one through the
// debug read port and streams it out as an {index, value} word.
module regbank_dump_tx #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_idx,
    input  logic [ADDR_W-1:0] last_idx,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [1:0]        state_dbg,
    regbank_dump_tx_if.master dump
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] last_r;
    logic [ADDR_W-1:0] idx_r;
    logic [DATA_W-1:0] data_r;
    logic              load;
    logic              capture;
    logic              advance;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cur    <= '0;
            last_r <= '0;
            idx_r  <= '0;
            data_r <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                cur    <= first_idx;
                last_r <= last_idx;
            end
            if (capture) begin
                idx_r  <= cur;
                data_r <= rf_rdata;
            end
            // NUM_REGS is a power of two, so the natural ADDR_W-bit wrap is the modulo.
            if (advance) begin
                cur <= cur + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        capture    = 1'b0;
        advance    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = READ;
                    load       = 1'b1;
                end
            end
            READ: begin
                state_next = SEND;
                capture    = 1'b1;
            end
            SEND: begin
                if (dump.out_ready) begin
                    if (cur == last_r) begin
                        state_next = DONE;
                    end else begin
                        state_next = READ;
                        advance    = 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy           = (state != IDLE);
    assign done           = (state == DONE);
    assign rf_raddr       = (state == IDLE) ? '0 : cur;
    assign state_dbg      = state;
    assign dump.out_valid = (state == SEND);
    assign dump.out_index = idx_r;
    assign dump.out_data  = data_r;

endmodule

// File: tb/tb_regbank_dump_tx.sv
// Self-checking bench for regbank_dump_tx: table of dump ranges plus hand-written
// backpressure, start-while-busy and mid-dump reset sequences.
module tb_regbank_dump_tx;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NREGS  = 32;
    localparam int W      = ADDR_W + DATA_W;
    localparam int BUDGET = 600;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] first_idx = '0;
    logic [ADDR_W-1:0] last_idx = '0;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic [1:0]        state_dbg;

    logic [DATA_W-1:0] bank [NREGS];

    regbank_dump_tx_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dif ();

    regbank_dump_tx #(.NUM_REGS(NREGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .first_idx (first_idx),
        .last_idx  (last_idx),
        .busy      (busy),
        .done      (done),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .state_dbg (state_dbg),
        .dump      (dif)
    );

    assign rf_rdata = bank[rf_raddr];

    // ---------------- clock / reset
    always #5 clock = ~clock;

    // ---------------- scoreboard state
    logic [W-1:0]      exp_q[$];
    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    int                start_cyc = 0;
    int                words = 0;
    int                done_cnt = 0;
    int                done_rel = -1;
    int                first_valid_rel = -1;
    bit                seen_valid = 1'b0;
    bit                prev_stall = 1'b0;
    logic [ADDR_W-1:0] prev_idx = '0;
    logic [DATA_W-1:0] prev_data = '0;
    int                ready_mode = 0;
    int                stall_cnt = 0;

    typedef struct {
        logic [ADDR_W-1:0] first;
        logic [ADDR_W-1:0] last;
        int                mode;       // 0: ready high, 1: random ready
        int                exp_words;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: observe at negedge, then let the edge pass and drive out_ready.
    task automatic cycle();
        logic [W-1:0] e;
        @(negedge clock);
        if (!reset_n) begin
            check("done_in_reset", {63'd0, done}, 64'd0);
            prev_stall = 1'b0;
        end else begin
            if (dif.out_valid && !seen_valid) begin
                seen_valid      = 1'b1;
                first_valid_rel = cyc - start_cyc;
            end
            if (prev_stall) begin
                check("stall_valid", {63'd0, dif.out_valid}, 64'd1);
                check("stall_index", {59'd0, dif.out_index}, {59'd0, prev_idx});
                check("stall_data", {32'd0, dif.out_data}, {32'd0, prev_data});
            end
            if (dif.out_valid && dif.out_ready) begin
                words++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word: got %0h:%0h expected no word", dif.out_index, dif.out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("word", {27'd0, dif.out_index, dif.out_data}, {27'd0, e});
                end
            end
            prev_stall = dif.out_valid && !dif.out_ready;
            prev_idx   = dif.out_index;
            prev_data  = dif.out_data;
            if (done) begin
                done_cnt++;
                done_rel = cyc - start_cyc;
            end
        end
        @(posedge clock);
        cyc++;
        #1;
        case (ready_mode)
            1: dif.out_ready = 1'($urandom_range(0, 1));
            2: begin
                if (dif.out_valid && stall_cnt < 5) begin
                    dif.out_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    dif.out_ready = 1'b1;
                    stall_cnt = 0;
                end
            end
            default: dif.out_ready = 1'b1;
        endcase
    endtask

    // ---------------- driver tasks
    task automatic begin_dump(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l, input int mode);
        logic [ADDR_W-1:0] idx;
        idx = f;
        forever begin
            exp_q.push_back({idx, bank[idx]});
            if (idx == l) break;
            idx = idx + ADDR_W'(1);
        end
        words           = 0;
        done_cnt        = 0;
        done_rel        = -1;
        first_valid_rel = -1;
        seen_valid      = 1'b0;
        stall_cnt       = 0;
        ready_mode      = mode;
        dif.out_ready   = 1'b1;
        start           = 1'b1;
        first_idx       = f;
        last_idx        = l;
        start_cyc       = cyc;
        cycle();
        start = 1'b0;
    endtask

    task automatic finish_dump(input int exp_words, input bit timed);
        int n;
        n = 0;
        while (done_cnt == 0 && n < BUDGET) begin
            cycle();
            n++;
        end
        if (done_cnt == 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", BUDGET);
        end
        check("busy_after_done", {63'd0, busy}, 64'd0);
        check("valid_after_done", {63'd0, dif.out_valid}, 64'd0);
        cycle();
        cycle();
        check("word_count", 64'(words), 64'(exp_words));
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("done_pulses", 64'(done_cnt), 64'd1);
        if (timed) begin
            // Cycle 0 is the cycle in which start is held high.
            check("first_valid_lat", 64'(first_valid_rel), 64'd2);
            check("done_lat", 64'(done_rel), 64'(2 * exp_words + 1));
        end
        exp_q.delete();
    endtask

    // ---------------- test sequence
    initial begin
        int n;
        for (int i = 0; i < NREGS; i++) bank[i] = '0;
        bank[8]  = 32'h0000_0064;
        bank[9]  = 32'h0000_03ec;
        bank[16] = 32'h03e8_0000;
        bank[19] = 32'hffff_ff9c;
        dif.out_ready = 1'b1;

        vecs[0] = '{first: 5'd0,  last: 5'd31, mode: 0, exp_words: 32};
        vecs[1] = '{first: 5'd30, last: 5'd1,  mode: 0, exp_words: 4};
        vecs[2] = '{first: 5'd21, last: 5'd21, mode: 0, exp_words: 1};
        vecs[3] = '{first: 5'd5,  last: 5'd12, mode: 1, exp_words: 8};
        vecs[4] = '{first: 5'd31, last: 5'd0,  mode: 1, exp_words: 2};

        // Reset values
        #22;
        check("rst_valid", {63'd0, dif.out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_raddr", {59'd0, rf_raddr}, 64'd0);
        check("rst_index", {59'd0, dif.out_index}, 64'd0);
        check("rst_data", {32'd0, dif.out_data}, 64'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        cycle();
        cycle();

        // Table of dump ranges
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                bank[10] = 32'h0000_038c;
                bank[21] = 32'h000f_4240;
            end
            begin_dump(vecs[i].first, vecs[i].last, vecs[i].mode);
            finish_dump(vecs[i].exp_words, vecs[i].mode == 0);
        end

        // Backpressure: 5 stalled cycles on each of 8..10
        begin_dump(5'd8, 5'd10, 2);
        finish_dump(3, 1'b0);

        // start with new range while busy is ignored
        begin_dump(5'd0, 5'd3, 0);
        n = 0;
        while (!dif.out_valid && n < 10) begin
            cycle();
            n++;
        end
        check("reached_send", {63'd0, dif.out_valid}, 64'd1);
        start     = 1'b1;
        first_idx = 5'd20;
        last_idx  = 5'd25;
        cycle();
        cycle();
        start = 1'b0;
        finish_dump(4, 1'b0);
        begin_dump(5'd20, 5'd25, 0);
        finish_dump(6, 1'b1);

        // Reset mid-dump after three words
        begin_dump(5'd0, 5'd31, 0);
        n = 0;
        while (words < 3 && n < 50) begin
            cycle();
            n++;
        end
        check("words_before_reset", 64'(words), 64'd3);
        #2 reset_n = 1'b0;
        #1;
        check("abort_valid", {63'd0, dif.out_valid}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_raddr", {59'd0, rf_raddr}, 64'd0);
        exp_q.delete();
        cycle();
        cycle();
        #2 reset_n = 1'b1;
        cycle();
        cycle();
        check("idle_after_abort", {62'd0, state_dbg}, 64'd0);
        check("no_done_on_abort", 64'(done_cnt), 64'd0);
        begin_dump(5'd0, 5'd31, 0);
        finish_dump(32, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
